pool_ctrl: RTL and testbench
============================

POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter IN_W, default 26, input feature-map width in pixels; even, >= 2.
REQ-002 Parameter IN_H, default 26, input feature-map height in rows; even, >= 2.
REQ-003 Parameter ADDR_W, default 10, read-address width; 2^ADDR_W >= IN_H*IN_W/2.
REQ-004 Parameter WB_LAT, default 15, writeback wait per output row, in cycles, >= 1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to pool one feature map.
REQ-008 pool_type_cfg  input  1  pooling mode for the run: 0 max, 1 average/min per comparator encoding.
REQ-009 stall  input  1  high freezes sequencing; no read issued that cycle.
REQ-010 rd_en  output  1  feature-map read strobe; one word = two horizontally adjacent pixels.
REQ-011 rd_addr  output  ADDR_W  word address = row*(IN_W/2) + pair.
REQ-012 en_comp1  output  1  first-stage compare/line-shift enable, aligned with returned data.
REQ-013 en_comp2  output  1  second-stage (vertical) compare enable, aligned with returned data.
REQ-014 pool_type  output  1  mode latched at start, held constant for the whole run.
REQ-015 pool_done  output  1  one-cycle pulse starting writeback of one output row.
REQ-016 busy  output  1  high from cycle after accepted start until done.
REQ-017 done  output  1  one-cycle pulse at end of run.

Function
REQ-018 States: IDLE, EVEN_ROW, ODD_ROW, DRAIN, WB, FIN.
REQ-019 IDLE: start=1 -> EVEN_ROW; row=0, pair=0, pool_type<=pool_type_cfg, busy<=1.
REQ-020 start while busy=1 ignored; pool_type_cfg sampled only on accepted start.
REQ-021 EVEN_ROW/ODD_ROW: each cycle with stall=0: rd_en=1, rd_addr per REQ-011, pair increments.
REQ-022 stall=1: rd_en=0, row/pair frozen, state held; stall ignored in IDLE, WB, FIN.
REQ-023 Read latency is 1 cycle: en_comp1 = rd_en delayed 1 cycle.
REQ-024 en_comp2 = (rd_en AND row odd) delayed 1 cycle; always 0 for even-row reads.
REQ-025 pair wraps IN_W/2-1 -> 0: EVEN_ROW -> ODD_ROW (row+1); ODD_ROW -> DRAIN.
REQ-026 DRAIN: one cycle, rd_en=0, lets last delayed compare enable issue; then -> WB.
REQ-027 WB entry cycle: pool_done=1 for exactly one cycle; wb counter loads 0.
REQ-028 WB: rd_en=0, en_comp1/2=0; after WB_LAT cycles -> EVEN_ROW (row+1) if row < IN_H-1, else -> FIN.
REQ-029 FIN: done=1 one cycle, busy<=0, -> IDLE.
REQ-030 Per run: IN_H*IN_W/2 reads, IN_H/2 pool_done pulses, one done pulse.
REQ-031 Counters sized to hold IN_H-1, IN_W/2-1, WB_LAT without overflow; no address wrap within a run.
REQ-032 Simultaneous stall and final pair: stall wins; transition occurs on first unstalled cycle.
REQ-033 Start and done in same cycle cannot occur; start in FIN cycle ignored.

Reset
REQ-034 rst=0 at any time, including mid-run: state IDLE, counters 0, and rd_en, en_comp1, en_comp2, pool_done, busy, done, pool_type, rd_addr all 0, immediately (asynchronous).
REQ-035 After rst release, no activity until a new start; no partial run resumes.

Verification
REQ-036 IN_W=4, IN_H=2, start, pool_type_cfg=1, no stall -> rd_addr 0,1,2,3 on consecutive cycles; en_comp1 high 4 cycles lagging by 1; en_comp2 high only for addr 2,3 data; pool_type=1; one pool_done; done after WB_LAT cycles.
REQ-037 Default params, no stall -> 338 rd_en cycles, 13 pool_done pulses spaced 26+1+WB_LAT cycles apart, one done pulse, busy high throughout.
REQ-038 IN_W=4, IN_H=2, stall high 3 cycles at pair=1 of row 0 -> rd_addr holds, rd_en=0 those cycles, sequence resumes at addr 1, total reads still 4.
REQ-039 start pulsed again mid-run with pool_type_cfg toggled -> ignored; pool_type unchanged; read count unchanged.
REQ-040 rst asserted during WB of row 1 -> all outputs 0 same cycle; after release, start -> run begins at rd_addr 0.
REQ-041 pool_type_cfg=0 start, then pool_type_cfg=1 after one cycle -> pool_type stays 0 until done.

Source files
------------

// File: rtl/pool_ctrl_if.sv
// pool_ctrl handshake bundle.
// Sequencer requests in, read and compare strobes out.
interface pool_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              pool_type_cfg;
  logic              stall;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              en_comp1;
  logic              en_comp2;
  logic              pool_type;
  logic              pool_done;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output pool_type_cfg,
    output stall,
    input  rd_en,
    input  rd_addr,
    input  en_comp1,
    input  en_comp2,
    input  pool_type,
    input  pool_done,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  pool_type_cfg,
    input  stall,
    output rd_en,
    output rd_addr,
    output en_comp1,
    output en_comp2,
    output pool_type,
    output pool_done,
    output busy,
    output done
  );
endinterface

// File: rtl/pool_ctrl.sv
// 2x2 pooling sequencer: walks row pairs of a feature map,
// issues pixel-pair reads and compare enables, then waits writeback.
module pool_ctrl #(
  parameter int IN_W   = 26,
  parameter int IN_H   = 26,
  parameter int ADDR_W = 10,
  parameter int WB_LAT = 15
) (
  input  logic   clk,
  input  logic   rst,
  pool_ctrl_if.slave bus
);

  localparam int HALF = IN_W / 2;
  localparam int RW   = $clog2(IN_H);
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(WB_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVEN  = 3'd1;
  localparam logic [2:0] S_ODD   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [PW-1:0] PAIR_LAST = PW'(HALF - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IN_H - 1);
  localparam logic [CW-1:0] WB_LAST   = CW'(WB_LAT - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(HALF);

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] pair_q, pair_d;
  logic [CW-1:0] wb_q, wb_d;
  logic          busy_q, busy_d;
  logic          pt_q, pt_d;
  logic          c1_q, c1_d;
  logic          c2_q, c2_d;
  logic          rd_en;
  logic          pool_done;
  logic          done;
  logic          reading;

  assign reading = (state_q == S_EVEN) || (state_q == S_ODD);

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pair_d    = pair_q;
    wb_d      = wb_q;
    busy_d    = busy_q;
    pt_d      = pt_q;
    rd_en     = 1'b0;
    pool_done = 1'b0;
    done      = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.start) begin
          state_d = S_EVEN;
          row_d   = '0;
          pair_d  = '0;
          pt_d    = bus.pool_type_cfg;
          busy_d  = 1'b1;
        end
      end
      reading: begin
        if (!bus.stall) begin
          rd_en = 1'b1;
          if (pair_q == PAIR_LAST) begin
            pair_d = '0;
            if (state_q == S_EVEN) begin
              row_d   = row_q + 1'b1;
              state_d = S_ODD;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            pair_d = pair_q + 1'b1;
          end
        end
      end
      (state_q == S_DRAIN): begin
        if (!bus.stall) begin
          state_d = S_WB;
          wb_d    = '0;
        end
      end
      (state_q == S_WB): begin
        pool_done = (wb_q == '0);
        if (wb_q == WB_LAST) begin
          if (row_q < ROW_LAST) begin
            row_d   = row_q + 1'b1;
            state_d = S_EVEN;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          wb_d = wb_q + 1'b1;
        end
      end
      (state_q == S_FIN): begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Data comes back one cycle after the read, so enables lag rd_en.
  always_comb begin
    c1_d = rd_en;
    c2_d = rd_en & row_q[0];
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      pair_q  <= '0;
      wb_q    <= '0;
      busy_q  <= 1'b0;
      pt_q    <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      wb_q    <= wb_d;
      busy_q  <= busy_d;
      pt_q    <= pt_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = ADDR_W'(row_q) * ROW_STRIDE
                       + ADDR_W'(pair_q);
  assign bus.en_comp1  = c1_q;
  assign bus.en_comp2  = c2_q;
  assign bus.pool_type = pt_q;
  assign bus.pool_done = pool_done;
  assign bus.busy      = busy_q;
  assign bus.done      = done;

endmodule

// File: tb/tb_pool_ctrl.sv
// Randomized scoreboard bench for pool_ctrl.
// Expected reads queued at start; monitor checks each cycle.
module tb_pool_ctrl;
  localparam int IN_W   = 4;
  localparam int IN_H   = 4;
  localparam int ADDR_W = 4;
  localparam int WB_LAT = 3;
  localparam int HALF   = IN_W / 2;
  localparam int NRD    = IN_W * IN_H / 2;
  localparam int NRUNS  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pool_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  pool_ctrl #(
    .IN_W(IN_W), .IN_H(IN_H),
    .ADDR_W(ADDR_W), .WB_LAT(WB_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  bit c2_q[$];

  bit m_active  = 0;
  bit m_pt      = 0;
  bit m_fin     = 0;
  bit m_prev_rd = 0;
  int m_wait    = 0;
  int m_reads   = 0;
  int m_pd      = 0;
  int m_runs    = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model and monitor, evaluated mid-cycle.
  always @(negedge clk) begin : mon
    bit was;
    bit er;
    bit epd;
    bit edn;
    int a;
    if (!rst) begin
      chk("reset_outs",
          {bus.rd_en, bus.rd_addr, bus.en_comp1, bus.en_comp2,
           bus.pool_done, bus.busy, bus.done, bus.pool_type}, 0);
      exp_q.delete();
      c2_q.delete();
      m_active  = 0;
      m_fin     = 0;
      m_wait    = 0;
      m_prev_rd = 0;
      m_reads   = 0;
      m_pd      = 0;
    end else begin
      was = m_active;
      er  = 0;
      epd = 0;
      edn = 0;
      chk("busy", bus.busy, m_active);
      chk("en_comp1", bus.en_comp1, m_prev_rd);
      if (m_prev_rd && c2_q.size() > 0)
        chk("en_comp2", bus.en_comp2, c2_q.pop_front());
      else
        chk("en_comp2_idle", bus.en_comp2, 0);
      if (m_active) begin
        chk("pool_type", bus.pool_type, m_pt);
        if (m_wait > 0) begin
          epd = (m_wait == WB_LAT);
          if (epd) m_pd++;
          if (!(m_wait == WB_LAT + 1 && bus.stall)) m_wait--;
          if (m_wait == 0 && exp_q.size() == 0) m_fin = 1;
        end else if (m_fin) begin
          edn = 1;
        end else if (exp_q.size() > 0) begin
          chk("rd_addr", bus.rd_addr, exp_q[0]);
          er = !bus.stall;
          if (er) begin
            a = exp_q.pop_front();
            c2_q.push_back(((a / HALF) % 2) == 1);
            m_reads++;
            if ((a + 1) % IN_W == 0) m_wait = WB_LAT + 1;
          end
        end
      end
      chk("rd_en", bus.rd_en, er);
      chk("pool_done", bus.pool_done, epd);
      chk("done", bus.done, edn);
      if (edn) begin
        chk("reads_per_run", m_reads, NRD);
        chk("pd_per_run", m_pd, IN_H / 2);
        m_active = 0;
        m_fin    = 0;
        m_runs++;
      end
      if (!was && bus.start) begin
        m_active = 1;
        m_pt     = bus.pool_type_cfg;
        m_reads  = 0;
        m_pd     = 0;
      end
      m_prev_rd = er;
    end
  end

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One run: accepted start, then random stall/start/cfg noise.
  task automatic run_once(int pct, bit mid_reset);
    bit fin_ok;
    @(posedge clk);
    #1;
    bus.start         = 1'b1;
    bus.pool_type_cfg = 1'($urandom);
    bus.stall         = 1'($urandom % 100 < pct);
    for (int i = 0; i < NRD; i++) exp_q.push_back(i);
    fin_ok = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      bus.pool_type_cfg = 1'($urandom);
      bus.stall         = 1'($urandom % 100 < pct);
      bus.start         = m_active && ($urandom % 6 == 0);
      if (!m_active) begin
        bus.start = 1'b0;
        fin_ok    = 1;
        break;
      end
      if (mid_reset && m_pd == 1) begin
        bus.start = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outs",
            {bus.rd_en, bus.rd_addr, bus.en_comp1,
             bus.en_comp2, bus.pool_done, bus.busy,
             bus.done, bus.pool_type}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fin_ok = 1;
        break;
      end
    end
    if (!fin_ok) begin
      chk("run_timeout", 1, 0);
      bus.start = 1'b0;
      pulse_reset();
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.pool_type_cfg = 1'b0;
    bus.stall         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int r = 0; r < NRUNS; r++) begin
      run_once((r % 3 == 0) ? 0 : 35, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    run_once(0, 1'b1);
    repeat (2) @(posedge clk);
    run_once(25, 1'b0);
    repeat (4) @(posedge clk);
    chk("runs_completed", m_runs, NRUNS + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
